// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//  Moore sequencer for a multi-cycle datapath. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB style states and decodes every datapath enable from the
//  current state.
// Ports
//  clk, reset            : rising-edge clock, asynchronous active-high reset (forces FETCH)
//  opcode                : IR[31:26], held by the IR for the whole instruction
//  mem_ready             : memory completes the current access this cycle
//  PCWrite, PCWriteCond  : PC load (unconditional / if ALU zero)
//  IorD, MemRead, MemWrite, IRWrite : memory interface controls
//  MemtoReg, RegDst, RegWrite       : regfile write controls
//  ALUSrcA, ALUSrcB, ALUOp, PCSource : ALU and PC mux selects
//  state                 : current state code (debug)
//  illegal_op            : one-cycle pulse in DECODE on an unsupported opcode
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_t;

  state_t state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  if (mem_ready) state_q <= StDecode;
        StDecode: begin
          if (opcode == OP_LW || opcode == OP_SW) state_q <= StMemAdr;
          else if (opcode == OP_RTYPE)            state_q <= StExec;
          else if (opcode == OP_BEQ)              state_q <= StBranch;
          else if (opcode == OP_J)                state_q <= StJump;
          else if (opcode == OP_ADDI)             state_q <= StAddiEx;
          else                                    state_q <= StFetch;
        end
        // Only LW and SW reach MEMADR, so anything that is not LW is a store.
        StMemAdr: state_q <= (opcode == OP_LW) ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state_q <= StMemWb;
        StMemWb:  state_q <= StFetch;
        StMemWr:  if (mem_ready) state_q <= StFetch;
        StExec:   state_q <= StRwb;
        StRwb:    state_q <= StFetch;
        StBranch: state_q <= StFetch;
        StJump:   state_q <= StFetch;
        StAddiEx: state_q <= StAddiWb;
        StAddiWb: state_q <= StFetch;
        // Unused codes 12-15 recover to FETCH.
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic op_known;
  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    PCSource    = 2'd0;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        // PC and IR load on the cycle the fetch completes; held off during reset.
        IRWrite = mem_ready & ~reset;
        PCWrite = mem_ready & ~reset;
      end
      StDecode: begin
        ALUSrcB    = 2'd3;
        illegal_op = ~op_known;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'd2;
      end
      StRwb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//  Directed bench for mc_control_fsm. The stimulus process drives one cycle of inputs
//  and pushes the hand-computed expected state/control word into a queue; the monitor
//  pops one entry per cycle on the falling edge and compares.
//  Control word bit order:
//  {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], illegal_op}
module tb_mc_control_fsm;

  logic       clk = 1'b1;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  //                                 PW PC ID MR MW IR MT RD RW SA SB  OP  PS  IL
  localparam logic [16:0] C_FETCH  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCHR = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total = total + 1;
      if (state !== e.st || act_ctl !== e.ctl) begin
        bad = bad + 1;
        $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                 e.name, state, act_ctl, e.st, e.ctl);
      end
    end
  end

  // Drive one cycle of inputs and record what the DUT should show during it.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] es, input logic [16:0] ec, input string nm);
    exp_t e;
    reset     = r;
    opcode    = op;
    mem_ready = mr;
    e.st   = es;
    e.ctl  = ec;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: FETCH decode with PCWrite/IRWrite gated even though mem_ready=1.
    step(1'b1, 6'h00, 1'b1, 4'd0, C_FETCH, "reset_fetch");
    step(1'b1, 6'h00, 1'b1, 4'd0, C_FETCH, "reset_fetch2");

    // LW, no waits: 0,1,2,3,4
    step(1'b0, 6'h23, 1'b1, 4'd0, C_FETCHR, "lw_fetch");
    step(1'b0, 6'h23, 1'b1, 4'd1, C_DECODE, "lw_decode");
    step(1'b0, 6'h23, 1'b1, 4'd2, C_MEMADR, "lw_memadr");
    step(1'b0, 6'h23, 1'b1, 4'd3, C_MEMRD,  "lw_memrd");
    step(1'b0, 6'h23, 1'b1, 4'd4, C_MEMWB,  "lw_memwb");

    // SW with 3 wait cycles in MEMWR: MemWrite held 4 cycles
    step(1'b0, 6'h2B, 1'b1, 4'd0, C_FETCHR, "sw_fetch");
    step(1'b0, 6'h2B, 1'b1, 4'd1, C_DECODE, "sw_decode");
    step(1'b0, 6'h2B, 1'b1, 4'd2, C_MEMADR, "sw_memadr");
    for (int i = 0; i < 3; i++) step(1'b0, 6'h2B, 1'b0, 4'd5, C_MEMWR, "sw_memwr_wait");
    step(1'b0, 6'h2B, 1'b1, 4'd5, C_MEMWR,  "sw_memwr_done");

    // R-type: 0,1,6,7
    step(1'b0, 6'h00, 1'b1, 4'd0, C_FETCHR, "r_fetch");
    step(1'b0, 6'h00, 1'b1, 4'd1, C_DECODE, "r_decode");
    step(1'b0, 6'h00, 1'b1, 4'd6, C_EXEC,   "r_exec");
    step(1'b0, 6'h00, 1'b1, 4'd7, C_RWB,    "r_rwb");

    // BEQ then J
    step(1'b0, 6'h04, 1'b1, 4'd0, C_FETCHR, "beq_fetch");
    step(1'b0, 6'h04, 1'b1, 4'd1, C_DECODE, "beq_decode");
    step(1'b0, 6'h04, 1'b1, 4'd8, C_BRANCH, "beq_branch");
    step(1'b0, 6'h02, 1'b1, 4'd0, C_FETCHR, "j_fetch");
    step(1'b0, 6'h02, 1'b1, 4'd1, C_DECODE, "j_decode");
    step(1'b0, 6'h02, 1'b1, 4'd9, C_JUMP,   "j_jump");

    // ADDI: 0,1,10,11
    step(1'b0, 6'h08, 1'b1, 4'd0,  C_FETCHR, "addi_fetch");
    step(1'b0, 6'h08, 1'b1, 4'd1,  C_DECODE, "addi_decode");
    step(1'b0, 6'h08, 1'b1, 4'd10, C_MEMADR, "addi_ex");
    step(1'b0, 6'h08, 1'b1, 4'd11, C_ADDIWB, "addi_wb");

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step(1'b0, 6'h3F, 1'b1, 4'd0, C_FETCHR, "ill_fetch");
    step(1'b0, 6'h3F, 1'b1, 4'd1, C_DECILL, "ill_decode");

    // FETCH stalls 5 cycles: no PC/IR load until the ready cycle
    for (int i = 0; i < 5; i++) step(1'b0, 6'h00, 1'b0, 4'd0, C_FETCH, "fetch_wait");
    step(1'b0, 6'h00, 1'b1, 4'd0, C_FETCHR, "fetch_ready");
    step(1'b0, 6'h00, 1'b1, 4'd1, C_DECODE, "fetch_decode");
    step(1'b0, 6'h00, 1'b1, 4'd6, C_EXEC,   "r2_exec");
    step(1'b0, 6'h00, 1'b1, 4'd7, C_RWB,    "r2_rwb");

    // Reset during MEMRD aborts the load: no MEMWB, no RegWrite
    step(1'b0, 6'h23, 1'b1, 4'd0, C_FETCHR, "abort_fetch");
    step(1'b0, 6'h23, 1'b1, 4'd1, C_DECODE, "abort_decode");
    step(1'b0, 6'h23, 1'b1, 4'd2, C_MEMADR, "abort_memadr");
    step(1'b0, 6'h23, 1'b0, 4'd3, C_MEMRD,  "abort_memrd");
    step(1'b1, 6'h23, 1'b1, 4'd0, C_FETCH,  "abort_reset");
    step(1'b0, 6'h23, 1'b0, 4'd0, C_FETCH,  "abort_release");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
